// File: rtl/cheshire_wdg_pkg.sv
// Shared types and defaults for the commit-stall watchdog.
package cheshire_wdg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wdg_state_e;

    localparam int unsigned MaxStallCyclesDefault = 10000;
    localparam int unsigned DrainCyclesDefault    = 100;

    // A zero-length window still needs a 1-bit counter to keep the RTL legal.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/commit_progress_detect.sv
// Combinational per-port comparison of committed PCs against the last seen PC.
module commit_progress_detect
    import cheshire_wdg_pkg::*;
#(
    parameter int unsigned PcWidth       = 64,
    parameter int unsigned NrCommitPorts = 2
) (
    input  logic [NrCommitPorts-1:0]              ack,
    input  logic [NrCommitPorts-1:0][PcWidth-1:0] pc,
    input  logic [PcWidth-1:0]                    last_pc,
    output logic                                  any_ack,
    output logic                                  progress,
    output logic [PcWidth-1:0]                    hi_pc
);

    logic [NrCommitPorts-1:0] new_pc;

    for (genvar p = 0; p < NrCommitPorts; p++) begin : g_port
        assign new_pc[p] = ack[p] && (pc[p] != last_pc);
    end

    assign any_ack  = |ack;
    assign progress = |new_pc;

    // Ascending scan so the highest-index acked port wins.
    always_comb begin
        hi_pc = '0;
        for (int p = 0; p < NrCommitPorts; p++) begin
            if (ack[p]) hi_pc = pc[p];
        end
    end

endmodule

// File: rtl/commit_stall_watchdog.sv
// Hung-core detector on the commit ports: declares a stall after MaxStallCycles
// without PC progress, then requests simulation end after a drain window.
module commit_stall_watchdog
    import cheshire_wdg_pkg::*;
#(
    parameter int unsigned PcWidth        = 64,
    parameter int unsigned NrCommitPorts  = 2,
    parameter int unsigned MaxStallCycles = MaxStallCyclesDefault,
    parameter int unsigned DrainCycles    = DrainCyclesDefault,
    localparam int unsigned CntWidth      = $clog2(MaxStallCycles + 1)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  en_i,
    input  logic                                  clear_i,
    input  logic [NrCommitPorts-1:0]              commit_ack_i,
    input  logic [NrCommitPorts-1:0][PcWidth-1:0] commit_pc_i,
    output logic                                  started_o,
    output logic                                  stalled_o,
    output logic [PcWidth-1:0]                    stall_pc_o,
    output logic [CntWidth-1:0]                   idle_cnt_o,
    output logic                                  finish_req_o
);

    localparam int unsigned DrainW = cnt_width(DrainCycles);

    wdg_state_e         state;
    logic [PcWidth-1:0] last_pc;
    logic [DrainW-1:0]  drain_cnt;

    logic               any_ack;
    logic               progress;
    logic [PcWidth-1:0] hi_pc;
    logic               stall_hit;
    logic               drain_hit;

    commit_progress_detect #(
        .PcWidth       (PcWidth),
        .NrCommitPorts (NrCommitPorts)
    ) i_detect (
        .ack      (commit_ack_i),
        .pc       (commit_pc_i),
        .last_pc  (last_pc),
        .any_ack  (any_ack),
        .progress (progress),
        .hi_pc    (hi_pc)
    );

    // Compare the pre-increment value so the counter never needs a carry bit.
    assign stall_hit = (idle_cnt_o == CntWidth'(MaxStallCycles - 1));
    assign drain_hit = (drain_cnt == DrainW'(DrainCycles - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state        <= IDLE;
            last_pc      <= '0;
            drain_cnt    <= '0;
            started_o    <= 1'b0;
            stalled_o    <= 1'b0;
            stall_pc_o   <= '0;
            idle_cnt_o   <= '0;
            finish_req_o <= 1'b0;
        end else if (en_i) begin
            case (state)
                IDLE: begin
                    if (any_ack) begin
                        started_o  <= 1'b1;
                        last_pc    <= hi_pc;
                        idle_cnt_o <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (any_ack) last_pc <= hi_pc;
                    // Progress on the threshold cycle still rescues the core.
                    if (progress) begin
                        idle_cnt_o <= '0;
                    end else if (stall_hit) begin
                        idle_cnt_o <= idle_cnt_o + CntWidth'(1);
                        stalled_o  <= 1'b1;
                        stall_pc_o <= last_pc;
                        drain_cnt  <= '0;
                        if (DrainCycles == 0) begin
                            finish_req_o <= 1'b1;
                            state        <= DONE;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        idle_cnt_o <= idle_cnt_o + CntWidth'(1);
                    end
                end
                DRAIN: begin
                    if (drain_hit) begin
                        finish_req_o <= 1'b1;
                        state        <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + DrainW'(1);
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
